// File: rtl/vc_fifo.sv
// Multi-channel FIFO: NUM_VC independent circular buffers with first-word-fall-through
// read data, per-channel occupancy flags and a sticky error flag for illegal accesses.
module vc_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4,
  parameter int NUM_VC     = 2,
  parameter int AF_THRESH  = (2 ** DEPTH_LOG2) - 2,
  localparam int VCW       = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              write,
  input  logic [VCW-1:0]                    write_vc,
  input  logic [WIDTH-1:0]                  item_in,
  input  logic                              read,
  input  logic [VCW-1:0]                    read_vc,
  output logic [WIDTH-1:0]                  item_out,
  output logic [NUM_VC-1:0]                 full,
  output logic [NUM_VC-1:0]                 empty,
  output logic [NUM_VC-1:0]                 almost_full,
  output logic [NUM_VC*(DEPTH_LOG2+1)-1:0]  count,
  output logic                              err
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0]      mem_r    [NUM_VC][DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_r [NUM_VC];
  logic [DEPTH_LOG2-1:0] rd_ptr_r [NUM_VC];
  logic [CW-1:0]         cnt_r    [NUM_VC];

  logic [NUM_VC-1:0] wr_hit_s;
  logic [NUM_VC-1:0] rd_hit_s;
  logic [NUM_VC-1:0] push_s;
  logic [NUM_VC-1:0] pop_s;
  logic              wr_bad_s;
  logic              rd_bad_s;

  // Channel decode and accept qualification; a select >= NUM_VC matches no channel.
  always_comb begin
    wr_hit_s = '0;
    rd_hit_s = '0;
    push_s   = '0;
    pop_s    = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      wr_hit_s[v] = (write_vc == VCW'(v));
      rd_hit_s[v] = (read_vc == VCW'(v));
      push_s[v]   = write & wr_hit_s[v] & (cnt_r[v] != CW'(DEPTH));
      pop_s[v]    = read & rd_hit_s[v] & (cnt_r[v] != CW'(0));
    end
    // Any request that no channel accepted is an error (bad select, full or empty).
    wr_bad_s = write & ~(|push_s);
    rd_bad_s = read & ~(|pop_s);
  end

  // Status flags and packed occupancy, all from the registered counts.
  always_comb begin
    full        = '0;
    empty       = '0;
    almost_full = '0;
    count       = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      full[v]             = (cnt_r[v] == CW'(DEPTH));
      empty[v]            = (cnt_r[v] == CW'(0));
      almost_full[v]      = (cnt_r[v] >= CW'(AF_THRESH));
      count[v*CW +: CW]   = cnt_r[v];
    end
  end

  // Fall-through head of the selected channel; zero when the select is out of range.
  always_comb begin
    item_out = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      item_out = item_out | (rd_hit_s[v] ? mem_r[v][rd_ptr_r[v]] : '0);
    end
  end

  // Storage, pointers, counts and sticky error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err <= 1'b0;
      for (int v = 0; v < NUM_VC; v++) begin
        wr_ptr_r[v] <= '0;
        rd_ptr_r[v] <= '0;
        cnt_r[v]    <= '0;
        for (int d = 0; d < DEPTH; d++) begin
          mem_r[v][d] <= '0;
        end
      end
    end else begin
      if (wr_bad_s || rd_bad_s) begin
        err <= 1'b1;
      end else begin
        err <= err;
      end
      for (int v = 0; v < NUM_VC; v++) begin
        if (push_s[v]) begin
          mem_r[v][wr_ptr_r[v]] <= item_in;
          wr_ptr_r[v]           <= wr_ptr_r[v] + 1'b1;
        end else begin
          wr_ptr_r[v] <= wr_ptr_r[v];
        end
        if (pop_s[v]) begin
          rd_ptr_r[v] <= rd_ptr_r[v] + 1'b1;
        end else begin
          rd_ptr_r[v] <= rd_ptr_r[v];
        end
        case ({push_s[v], pop_s[v]})
          2'b10:   cnt_r[v] <= cnt_r[v] + 1'b1;
          2'b01:   cnt_r[v] <= cnt_r[v] - 1'b1;
          default: cnt_r[v] <= cnt_r[v];
        endcase
      end
    end
  end

endmodule

// File: doc/vc_fifo.md
VC_FIFO -- requirements
Module: vc_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data item width in bits.
REQ-002 SHALL have parameter DEPTH_LOG2, default 4, log2 of per-channel depth (DEPTH = 2**DEPTH_LOG2).
REQ-003 SHALL have parameter NUM_VC, default 2, number of independent virtual channels (1..16).
REQ-004 SHALL have parameter AF_THRESH, default DEPTH-2, almost-full occupancy threshold (1..DEPTH).
REQ-005 SHALL derive VCW = max(1, ceil(log2(NUM_VC))) as the channel-select width.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-008 write  input  1  push request.
REQ-009 write_vc  input  VCW  target channel of push.
REQ-010 item_in  input  WIDTH  push data.
REQ-011 read  input  1  pop request.
REQ-012 read_vc  input  VCW  source channel of pop and of item_out.
REQ-013 item_out  output  WIDTH  head item of channel read_vc.
REQ-014 full  output  NUM_VC  per-channel full flag, bit v = channel v.
REQ-015 empty  output  NUM_VC  per-channel empty flag.
REQ-016 almost_full  output  NUM_VC  per-channel occupancy >= AF_THRESH.
REQ-017 count  output  NUM_VC*(DEPTH_LOG2+1)  per-channel occupancy, channel v in bits [v*(DEPTH_LOG2+1) +: DEPTH_LOG2+1].
REQ-018 err  output  1  sticky error flag.

Function
REQ-019 Each channel SHALL be an independent circular buffer of DEPTH entries with its own read pointer, write pointer (DEPTH_LOG2 bits, natural wrap DEPTH-1 -> 0) and count (0..DEPTH).
REQ-020 Push accepted iff write=1, write_vc < NUM_VC, full[write_vc]=0; item_in stored at that channel's write pointer, pointer +1, count +1 at the edge.
REQ-021 Pop accepted iff read=1, read_vc < NUM_VC, empty[read_vc]=0; read pointer +1, count -1 at the edge.
REQ-022 item_out SHALL be combinational first-word-fall-through: mem[read_vc][rd_ptr[read_vc]], zero-latency, valid whenever empty[read_vc]=0; 0 when read_vc >= NUM_VC.
REQ-023 full[v] = (count[v]==DEPTH), empty[v] = (count[v]==0), almost_full[v] = (count[v] >= AF_THRESH), all derived combinationally from registered count.
REQ-024 Push and pop to different channels in the same cycle SHALL both take effect.
REQ-025 Push and pop to the same non-full, non-empty channel in the same cycle SHALL both take effect; count unchanged.
REQ-026 Same-channel push while full SHALL be rejected even if a pop to that channel is accepted that cycle (count -> DEPTH-1).
REQ-027 Same-channel pop while empty SHALL be rejected even if a push to that channel is accepted that cycle (count -> 1).
REQ-028 Rejected push/pop SHALL not change any pointer, count or memory.
REQ-029 err SHALL set at the edge on any of: write=1 with full[write_vc]=1; read=1 with empty[read_vc]=1; write=1 with write_vc >= NUM_VC; read=1 with read_vc >= NUM_VC; cleared only by reset.
REQ-030 Channels SHALL never share storage; activity on one channel SHALL not alter another's state.

Reset
REQ-031 reset=0 SHALL immediately, without clk, clear all pointers, counts, memory contents and err.
REQ-032 During and after reset: empty all 1, full all 0, almost_full all 0, count all 0, item_out 0, err 0.
REQ-033 reset asserted mid-operation SHALL discard all stored items; accesses in the cycle reset deasserts are ignored; first accepted access on the first rising edge with reset=1.

Verification
REQ-034 Reset, then push 0x11,0x22,0x33 to VC1 -> count[1]=3, empty=2'b01, item_out=0x11 with read_vc=1; pops return 0x11,0x22,0x33 in order, then empty[1]=1.
REQ-035 Fill VC0 with 16 items (defaults) -> almost_full[0]=1 after 14th push, full[0]=1 after 16th; 17th push rejected, err=1, VC1 still empty.
REQ-036 VC0 full, same-cycle push 0xAA + pop to VC0 -> pop accepted, push rejected, count[0]=15, err=1.
REQ-037 VC1 empty, same-cycle push 0x5C + pop to VC1 -> push accepted, pop rejected, count[1]=1, item_out=0x5C, err=1.
REQ-038 Push 40 / pop 40 items on VC0 with interleaved same-cycle push+pop -> pointers wrap, data order preserved, count[0] ends 0, err=0.
REQ-039 VC0 holding 5 items, reset pulsed low between edges -> all outputs at reset values immediately; next push 0x01 to VC0 gives count[0]=1, item_out=0x01.
